trace_capture: RTL and testbench

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_pkg.sv | 26 ++
 rtl/trace_fifo.sv | 48 ++++
 rtl/trace_capture.sv | 124 ++++++++++++
 tb/tb_trace_capture.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and width constants for the trace capture block.
// The optional per-record cycle stamp is controlled by the TRACE_TIMESTAMP_EN macro.
package trace_pkg;

    localparam int TYPE_W         = 2;
    localparam int ADDR_W         = 9;
    localparam int TIME_W         = 16;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [TYPE_W-1:0] {
        REG_WB = 2'd0,
        MEM_RD = 2'd1,
        MEM_WR = 2'd2
    } trace_type_e;

    // Record layout at the default data width; trace_capture rebuilds it at its own DATA_W.
    typedef struct packed {
        trace_type_e                rec_type;
        logic [ADDR_W-1:0]          addr;
        logic [DEFAULT_DATA_W-1:0]  data;
`ifdef TRACE_TIMESTAMP_EN
        logic [TIME_W-1:0]          stamp;
`endif
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Record buffer accepting up to two records per cycle (rec_a first, then rec_b) with one pop.
// The producer must never push more records than there is free space.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter type rec_t = trace_rec_t
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 push_n,
    input  rec_t                       rec_a,
    input  rec_t                       rec_b,
    input  logic                       pop,
    output rec_t                       head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    rec_t            mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic            pop_ok;

    assign pop_ok = pop && (count != '0);
    assign head   = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(push_n);
            rptr  <= rptr + AW'(pop_ok);
            count <= count + (AW+1)'(push_n) - (AW+1)'(pop_ok);
        end
    end

    // NOTE: storage has no reset; emptiness is tracked by count alone, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) mem[wptr] <= rec_a;
        if (push_n == 2'd2) mem[wptr + AW'(1)] <= rec_b;
    end

endmodule

// File: rtl/trace_capture.sv
// Core trace capture: turns writeback and data-memory activity into ordered trace records.
// Define TRACE_TIMESTAMP_EN to stamp each record with a free-running 16-bit cycle count.
module trace_capture
    import trace_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               capture_en,
    input  logic [4:0]         reg_num,
    input  logic [DATA_W-1:0]  reg_data,
    input  logic               reg_write_sig,
    input  logic               wr,
    input  logic               rd,
    input  logic [8:0]         addr,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               trace_valid,
    input  logic               trace_ready,
    output logic [1:0]         trace_type,
    output logic [8:0]         trace_addr,
    output logic [DATA_W-1:0]  trace_data,
    output logic [15:0]        trace_time,
    output logic [15:0]        overflow_cnt,
    output logic               conflict
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        trace_type_e        rec_type;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  data;
`ifdef TRACE_TIMESTAMP_EN
        logic [TIME_W-1:0]  stamp;
`endif
    } rec_t;

    logic        reg_ev;
    logic        mem_ev;
    logic [1:0]  n_events;
    logic [AW:0] count;
    logic [AW:0] free;
    logic        drop;
    logic [1:0]  push_n;
    rec_t        reg_rec;
    rec_t        mem_rec;
    rec_t        rec_a;
    rec_t        head;

`ifdef TRACE_TIMESTAMP_EN
    logic [TIME_W-1:0] stamp_cnt;

    always_ff @(posedge clk) begin
        if (reset) stamp_cnt <= '0;
        else       stamp_cnt <= stamp_cnt + 16'd1;
    end
`endif

    assign reg_ev   = capture_en && reg_write_sig && (reg_num != 5'd0);
    assign mem_ev   = capture_en && (wr || rd);
    assign n_events = {1'b0, reg_ev} + {1'b0, mem_ev};
    // Free space is taken from the pre-pop count, so a same-cycle pop never makes room.
    assign free     = (AW+1)'(DEPTH) - count;
    assign drop     = (AW+1)'(n_events) > free;
    assign push_n   = drop ? 2'd0 : n_events;

    // NOTE: every field gets a default first so no path through this block can infer a latch.
    always_comb begin
        reg_rec          = '0;
        mem_rec          = '0;
        reg_rec.rec_type = REG_WB;
        reg_rec.addr     = ADDR_W'(reg_num);
        reg_rec.data     = reg_data;
        mem_rec.rec_type = wr ? MEM_WR : MEM_RD;
        mem_rec.addr     = addr;
        mem_rec.data     = wr ? wr_data : rd_data;
`ifdef TRACE_TIMESTAMP_EN
        reg_rec.stamp    = stamp_cnt;
        mem_rec.stamp    = stamp_cnt;
`endif
        // The writeback belongs to the older instruction, so it goes in first.
        rec_a            = reg_ev ? reg_rec : mem_rec;
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push_n (push_n),
        .rec_a  (rec_a),
        .rec_b  (mem_rec),
        .pop    (trace_ready),
        .head   (head),
        .count  (count)
    );

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_cnt <= '0;
            conflict     <= 1'b0;
        end else begin
            if (drop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
            if (capture_en && wr && rd)          conflict     <= 1'b1;
        end
    end

    assign trace_valid = (count != '0);
    assign trace_type  = trace_valid ? head.rec_type : 2'd0;
    assign trace_addr  = trace_valid ? head.addr : '0;
    assign trace_data  = trace_valid ? head.data : '0;

`ifdef TRACE_TIMESTAMP_EN
    assign trace_time  = trace_valid ? head.stamp : '0;
`else
    assign trace_time  = '0;
`endif

endmodule

// File: tb/tb_trace_capture.sv
// Directed self-checking bench for trace_capture at DATA_W=32, DEPTH=16.
// Stamp expectations follow TRACE_TIMESTAMP_EN the same way the design does.
module tb_trace_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        capture_en;
    logic [4:0]  reg_num;
    logic [31:0] reg_data;
    logic        reg_write_sig;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        trace_valid;
    logic        trace_ready;
    logic [1:0]  trace_type;
    logic [8:0]  trace_addr;
    logic [31:0] trace_data;
    logic [15:0] trace_time;
    logic [15:0] overflow_cnt;
    logic        conflict;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trace_capture #(.DATA_W(32), .DEPTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .capture_en    (capture_en),
        .reg_num       (reg_num),
        .reg_data      (reg_data),
        .reg_write_sig (reg_write_sig),
        .wr            (wr),
        .rd            (rd),
        .addr          (addr),
        .wr_data       (wr_data),
        .rd_data       (rd_data),
        .trace_valid   (trace_valid),
        .trace_ready   (trace_ready),
        .trace_type    (trace_type),
        .trace_addr    (trace_addr),
        .trace_data    (trace_data),
        .trace_time    (trace_time),
        .overflow_cnt  (overflow_cnt),
        .conflict      (conflict)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write_sig = 1'b0;
        reg_num       = 5'd0;
        reg_data      = 32'd0;
        wr            = 1'b0;
        rd            = 1'b0;
        addr          = 9'd0;
        wr_data       = 32'd0;
        rd_data       = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1; capture_en = 1'b1; trace_ready = 1'b0; idle();
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({trace_valid, overflow_cnt, conflict} !== {1'b0, 16'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got valid=%b ovf=%h conflict=%b exp 0/0000/0", trace_valid, overflow_cnt, conflict);
        end
        checks++;
        if ({trace_type, trace_addr, trace_data, trace_time} !== 59'd0) begin
            failures++;
            $display("FAIL reset_outputs got type=%h addr=%h data=%h time=%h exp all 0", trace_type, trace_addr, trace_data, trace_time);
        end
    endtask

    task automatic test_reg_wb();
        trace_ready = 1'b1;
        reg_write_sig = 1'b1; reg_num = 5'd5; reg_data = 32'hDEAD_BEEF;
        tick(); idle();
        checks++;
        if ({trace_valid, trace_type, trace_addr, trace_data} !== {1'b1, 2'd0, 9'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL reg_wb_rec got v=%b t=%0d a=%h d=%h exp v=1 t=0 a=005 d=deadbeef", trace_valid, trace_type, trace_addr, trace_data);
        end
        tick();
        checks++;
        if (trace_valid !== 1'b0) begin
            failures++;
            $display("FAIL reg_wb_pop got valid=%b exp 0", trace_valid);
        end
    endtask

    task automatic test_x0();
        trace_ready = 1'b1;
        reg_write_sig = 1'b1; reg_num = 5'd0; reg_data = 32'h1234_5678;
        tick(); tick(); idle();
        checks++;
        if (trace_valid !== 1'b0) begin
            failures++;
            $display("FAIL x0_no_record got valid=%b exp 0", trace_valid);
        end
    endtask

    task automatic test_dual_order();
        trace_ready = 1'b1;
        reg_write_sig = 1'b1; reg_num = 5'd3; reg_data = 32'h0000_0033;
        wr = 1'b1; addr = 9'h1F0; wr_data = 32'd7;
        tick(); idle();
        checks++;
        if ({trace_valid, trace_type, trace_addr, trace_data} !== {1'b1, 2'd0, 9'd3, 32'h33}) begin
            failures++;
            $display("FAIL dual_first got v=%b t=%0d a=%h d=%h exp v=1 t=0 a=003 d=00000033", trace_valid, trace_type, trace_addr, trace_data);
        end
        tick();
        checks++;
        if ({trace_valid, trace_type, trace_addr, trace_data} !== {1'b1, 2'd2, 9'h1F0, 32'd7}) begin
            failures++;
            $display("FAIL dual_second got v=%b t=%0d a=%h d=%h exp v=1 t=2 a=1f0 d=00000007", trace_valid, trace_type, trace_addr, trace_data);
        end
        tick();
        checks++;
        if (trace_valid !== 1'b0) begin
            failures++;
            $display("FAIL dual_drained got valid=%b exp 0", trace_valid);
        end
    endtask

    task automatic test_hold();
        trace_ready = 1'b0;
        reg_write_sig = 1'b1; reg_num = 5'd7; reg_data = 32'h70;
        tick(); idle();
        rd = 1'b1; addr = 9'h100; rd_data = 32'h99;
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({trace_valid, trace_type, trace_addr, trace_data} !== {1'b1, 2'd0, 9'd7, 32'h70}) begin
                failures++;
                $display("FAIL hold_stable[%0d] got v=%b t=%0d a=%h d=%h exp v=1 t=0 a=007 d=00000070", i, trace_valid, trace_type, trace_addr, trace_data);
            end
            tick();
        end
        trace_ready = 1'b1;
        tick();
        checks++;
        if ({trace_valid, trace_type, trace_addr, trace_data} !== {1'b1, 2'd1, 9'h100, 32'h99}) begin
            failures++;
            $display("FAIL hold_rd_rec got v=%b t=%0d a=%h d=%h exp v=1 t=1 a=100 d=00000099", trace_valid, trace_type, trace_addr, trace_data);
        end
        tick();
    endtask

    task automatic test_capture_en();
        trace_ready = 1'b0;
        rd = 1'b1; addr = 9'h042; rd_data = 32'h4242;
        tick(); idle();
        capture_en = 1'b0; trace_ready = 1'b1;
        reg_write_sig = 1'b1; reg_num = 5'd9; wr = 1'b1; addr = 9'h0AA;
        tick(); tick(); idle();
        capture_en = 1'b1;
        checks++;
        if (trace_valid !== 1'b0) begin
            failures++;
            $display("FAIL capture_off got valid=%b exp 0 (drained, nothing new)", trace_valid);
        end
    endtask

    task automatic test_overflow();
        trace_ready = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            reg_write_sig = 1'b1; reg_num = 5'(i); reg_data = 32'(i * 16);
            tick();
        end
        idle();
        reg_write_sig = 1'b1; reg_num = 5'd20; reg_data = 32'hBAD0;
        wr = 1'b1; addr = 9'h0BB; wr_data = 32'hBAD1;
        tick(); idle();
        checks++;
        if (overflow_cnt !== 16'd1) begin
            failures++;
            $display("FAIL ovf_pair_drop got ovf=%0d exp 1", overflow_cnt);
        end
        rd = 1'b1; addr = 9'h055; rd_data = 32'hAA;
        tick(); idle();
        checks++;
        if (overflow_cnt !== 16'd1) begin
            failures++;
            $display("FAIL ovf_single_fit got ovf=%0d exp 1", overflow_cnt);
        end
        wr = 1'b1; addr = 9'h0CC; wr_data = 32'hCC;
        tick(); idle();
        checks++;
        if (overflow_cnt !== 16'd2) begin
            failures++;
            $display("FAIL ovf_full_drop got ovf=%0d exp 2", overflow_cnt);
        end
        trace_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            logic [43:0] exp_rec;
            exp_rec = (i == 16) ? {2'd1, 9'h055, 32'hAA, 1'b1} : {2'd0, 9'(i), 32'(i * 16), 1'b1};
            checks++;
            if ({trace_type, trace_addr, trace_data, trace_valid} !== exp_rec) begin
                failures++;
                $display("FAIL ovf_drain[%0d] got %h exp %h", i, {trace_type, trace_addr, trace_data, trace_valid}, exp_rec);
            end
            tick();
        end
        checks++;
        if (trace_valid !== 1'b0) begin
            failures++;
            $display("FAIL ovf_drain_empty got valid=%b exp 0 (count was not 16)", trace_valid);
        end
    endtask

    task automatic test_conflict();
        trace_ready = 1'b0;
        wr = 1'b1; rd = 1'b1; addr = 9'h010; wr_data = 32'h11; rd_data = 32'h22;
        tick(); idle();
        checks++;
        if ({trace_valid, trace_type, trace_addr, trace_data, conflict} !== {1'b1, 2'd2, 9'h010, 32'h11, 1'b1}) begin
            failures++;
            $display("FAIL conflict_rec got v=%b t=%0d a=%h d=%h c=%b exp v=1 t=2 a=010 d=00000011 c=1", trace_valid, trace_type, trace_addr, trace_data, conflict);
        end
        trace_ready = 1'b1;
        tick(); tick(); tick();
        checks++;
        if ({trace_valid, conflict} !== 2'b01) begin
            failures++;
            $display("FAIL conflict_sticky got valid=%b conflict=%b exp 0/1 (single record, flag held)", trace_valid, conflict);
        end
    endtask

    task automatic test_back_to_back_reset();
        logic [15:0] exp_time;
        trace_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            reg_write_sig = 1'b1; reg_num = 5'(i + 1); wr = 1'b1; addr = 9'(i);
            tick();
        end
        reset = 1'b1;
        tick(); idle();
        reset = 1'b0;
        checks++;
        if ({trace_valid, overflow_cnt, conflict, trace_data} !== 50'd0) begin
            failures++;
            $display("FAIL reset_mid_drain got v=%b ovf=%h c=%b d=%h exp all 0", trace_valid, overflow_cnt, conflict, trace_data);
        end
        trace_ready = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (trace_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_records got valid=%b exp 0", trace_valid);
        end
        trace_ready = 1'b0;
        reg_write_sig = 1'b1; reg_num = 5'd4; reg_data = 32'h44;
        wr = 1'b1; addr = 9'h004; wr_data = 32'h45;
        tick(); idle();
`ifdef TRACE_TIMESTAMP_EN
        exp_time = 16'd3;
`else
        exp_time = 16'd0;
`endif
        checks++;
        if ({trace_valid, trace_type, trace_time} !== {1'b1, 2'd0, exp_time}) begin
            failures++;
            $display("FAIL post_reset_stamp got v=%b t=%0d time=%0d exp v=1 t=0 time=%0d", trace_valid, trace_type, trace_time, exp_time);
        end
        trace_ready = 1'b1;
        tick();
        checks++;
        if ({trace_valid, trace_type, trace_time} !== {1'b1, 2'd2, exp_time}) begin
            failures++;
            $display("FAIL same_cycle_stamp got v=%b t=%0d time=%0d exp v=1 t=2 time=%0d", trace_valid, trace_type, trace_time, exp_time);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_reg_wb();
        test_x0();
        test_dual_order();
        test_hold();
        test_capture_en();
        test_overflow();
        test_conflict();
        test_back_to_back_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
